simd_vec_exec: RTL and testbench
================================

Name: simd_vec_exec

Overview:
Parametrised SIMD execute unit, successor to the fixed 8x32 SIMD datapath.
- LANES identical lane ALUs operate on packed S/T vectors under a per-lane write mask.
- Results go into packed LO/HI accumulators; per-lane C/V/N/Z flags are kept alongside.
- Results are read back either randomly (rd_sel/rd_data) or streamed lane-by-lane over a valid/ready drain port to the scalar pipeline.

Parameters:
LANES, 8, lane count; power of 2, range 2..16
LANE_W, 32, lane width in bits; power of 2, range 8..64
(derived) IDX_W = clog2(LANES), SH_W = clog2(LANE_W)

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-low reset
in_valid  in  1  operation request
in_ready  out  1  unit accepts operation
fs  in  4  function select
lane_mask  in  LANES  lane write-enable; bit i gates lane i's LO/HI/flags
lo_ld  in  1  write LO for masked lanes
hi_ld  in  1  write HI for masked lanes
s_vec  in  LANES*LANE_W  packed S operands; lane i = [i*LANE_W +: LANE_W]
t_vec  in  LANES*LANE_W  packed T operands, same packing
rd_sel  in  IDX_W+1  random read select; MSB=1 selects HI, low bits select lane
rd_data  out  LANE_W  selected LO/HI lane, combinational from registers
drain_start  in  1  begin streaming LO (drain_hi=0) or HI (drain_hi=1)
drain_hi  in  1  bank for the drain, sampled with drain_start
out_valid  out  1  drain word valid
out_ready  in  1  consumer accepts drain word
out_data  out  LANE_W  drain word
out_lane  out  IDX_W  lane index of out_data
out_last  out  1  out_data is lane LANES-1
busy  out  1  state != IDLE
flag_c, flag_v, flag_n, flag_z  out  LANES each  per-lane flag registers

Behaviour:
- Reset (reset=0, asynchronous):
  - state=IDLE; LO, HI and all flags cleared to 0.
  - out_valid=0, out_lane=0, busy=0, in_ready=0.
- in_ready = (state==IDLE) & ~drain_start & reset. drain_start has priority over in_valid.
- FSM states IDLE, EXEC, DRAIN.
- IDLE:
  - in_valid&in_ready: register fs, lane_mask, lo_ld, hi_ld, s_vec, t_vec; go to EXEC.
  - drain_start: latch drain_hi, set lane ptr=0; go to DRAIN.
- EXEC (exactly 1 cycle):
  - For each lane i with mask bit set: LO[i] <= y_lo if lo_ld; HI[i] <= y_hi if hi_ld.
  - Flags are written for every masked lane, independent of lo_ld/hi_ld.
  - Unmasked lanes hold all state. Return to IDLE.
  - Latency: accepted at edge E0, results visible on rd_data after E1. Throughput is 1 op per 2 cycles.
- DRAIN:
  - out_valid=1; out_data = bank[ptr]; out_lane=ptr; out_last=(ptr==LANES-1).
  - out_valid&out_ready: ptr+1; on the last lane go to IDLE (out_valid=0 next cycle).
  - out_ready=0 holds all drain outputs stable.
  - Registers cannot change during DRAIN, because no op is accepted.
- Lane ALU, all arithmetic modulo 2^LANE_W; y_hi=0 unless stated:
  - 0000 pass S
  - 0001 S+T
  - 0010 S-T
  - 0011 and; 0100 or; 0101 xor
  - 0110 signed SLT: y_lo = 1 or 0
  - 0111 sll S by T[SH_W-1:0]
  - 1000 srl; 1001 sra
  - 1010 signed mul: {y_hi,y_lo} = 2*LANE_W-bit product
  - 1011 unsigned mul
  - 1100-1111: y_lo=y_hi=0
- Flags:
  - C = carry-out of add, or of S+~T+1 for sub (1 = no borrow); 0 for other ops.
  - V = signed overflow for add/sub; 0 otherwise.
  - N = y_lo MSB, or y_hi MSB for mul.
  - Z = (y_lo==0), or ({y_hi,y_lo}==0) for mul.
- lane_mask=0 with in_valid: op is accepted and takes EXEC, but no state changes.
- Reset asserted mid-EXEC or mid-DRAIN aborts immediately; a partial drain is not resumed.

Decomposition:
- Package simd_pkg holds:
  - FS opcode localparams (FS_PASS..FS_MULU).
  - FSM state encoding (ST_IDLE, ST_EXEC, ST_DRAIN).
  - clog2 helper function.
- Sub-module simd_lane_alu, parameter LANE_W, purely combinational:
  - Inputs s, t, fs.
  - Outputs y_lo, y_hi, c, v, n, z.
  - Instantiated LANES times via generate.
- Registers, mask gating, FSM and drain mux live in simd_vec_exec.

Test Plan:
- Reset: hold reset=0 3 cycles, then release → rd_data=0 for all 16 rd_sel values; flags 0; in_ready=1, busy=0.
- Masked add (LANES=8, LANE_W=32): lane i S=0x7FFFFFFF+i, T=1, mask=0x0F, lo_ld=1 → lane0 LO=0x80000000 with V=1, N=1; lane1 LO=0x80000001; lanes 4-7 LO=0 with flags 0; rd_data valid one cycle after EXEC.
- Sub/borrow: S=0, T=1 all lanes, mask=0xFF → LO=0xFFFFFFFF, C=0, N=1, Z=0; then S=5, T=5 → LO=0, C=1, Z=1.
- Signed mul with hi_ld=lo_ld=1: S=0xFFFFFFFF (-1), T=2 → LO=0xFFFFFFFE, HI=0xFFFFFFFF; same operands with fs=1011 → HI=0x00000001.
- Drain with backpressure: LO lane i=0x100+i, drain_start (drain_hi=0) with in_valid=1 same cycle → op not accepted; 8 words 0x100..0x107 stream out; out_ready toggled 1/0 holds data stable; out_last only on lane 7; busy drops after the last handshake.
- Reset mid-drain after 3 words → out_valid=0 immediately, LO cleared; a new drain_start streams 8 zero words starting at lane 0.

Source files
------------

// File: rtl/simd_pkg.sv
// Shared opcodes, FSM state encoding and elaboration helpers for the SIMD execute unit.
package simd_pkg;

    localparam logic [3:0] FS_PASS = 4'h0;
    localparam logic [3:0] FS_ADD  = 4'h1;
    localparam logic [3:0] FS_SUB  = 4'h2;
    localparam logic [3:0] FS_AND  = 4'h3;
    localparam logic [3:0] FS_OR   = 4'h4;
    localparam logic [3:0] FS_XOR  = 4'h5;
    localparam logic [3:0] FS_SLT  = 4'h6;
    localparam logic [3:0] FS_SLL  = 4'h7;
    localparam logic [3:0] FS_SRL  = 4'h8;
    localparam logic [3:0] FS_SRA  = 4'h9;
    localparam logic [3:0] FS_MULS = 4'hA;
    localparam logic [3:0] FS_MULU = 4'hB;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_EXEC  = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    function automatic int unsigned clog2(input int unsigned v);
        int unsigned r;
        int unsigned p;
        r = 0;
        p = 1;
        while (p < v) begin
            p = p << 1;
            r++;
        end
        return r;
    endfunction

endpackage

// File: rtl/simd_lane_alu.sv
// One combinational SIMD lane: arithmetic/logic/shift/multiply plus C/V/N/Z flag generation.
module simd_lane_alu
    import simd_pkg::*;
#(
    parameter  int unsigned LANE_W = 32,
    localparam int unsigned SH_W   = clog2(LANE_W)
) (
    input  logic [LANE_W-1:0] s,
    input  logic [LANE_W-1:0] t,
    input  logic [3:0]        fs,
    output logic [LANE_W-1:0] y_lo,
    output logic [LANE_W-1:0] y_hi,
    output logic              c,
    output logic              v,
    output logic              n,
    output logic              z
);

    logic [LANE_W:0]     sum;
    logic [LANE_W:0]     diff;
    logic [2*LANE_W-1:0] prod_s;
    logic [2*LANE_W-1:0] prod_u;
    logic [SH_W-1:0]     sh;
    logic                is_mul;

    assign sum  = {1'b0, s} + {1'b0, t};
    assign diff = {1'b0, s} + {1'b0, ~t} + (LANE_W+1)'(1);
    // Sign-extending both operands to 2W makes the truncated unsigned product the signed product.
    assign prod_s = {{LANE_W{s[LANE_W-1]}}, s} * {{LANE_W{t[LANE_W-1]}}, t};
    assign prod_u = {{LANE_W{1'b0}}, s} * {{LANE_W{1'b0}}, t};
    assign sh     = t[SH_W-1:0];
    assign is_mul = (fs == FS_MULS) || (fs == FS_MULU);

    always_comb begin
        y_lo = '0;
        y_hi = '0;
        c    = 1'b0;
        v    = 1'b0;
        case (fs)
            FS_PASS: y_lo = s;
            FS_ADD: begin
                y_lo = sum[LANE_W-1:0];
                c    = sum[LANE_W];
                v    = (s[LANE_W-1] == t[LANE_W-1]) && (sum[LANE_W-1] != s[LANE_W-1]);
            end
            FS_SUB: begin
                y_lo = diff[LANE_W-1:0];
                c    = diff[LANE_W];
                v    = (s[LANE_W-1] != t[LANE_W-1]) && (diff[LANE_W-1] != s[LANE_W-1]);
            end
            FS_AND:  y_lo = s & t;
            FS_OR:   y_lo = s | t;
            FS_XOR:  y_lo = s ^ t;
            FS_SLT:  y_lo = {{(LANE_W-1){1'b0}}, ($signed(s) < $signed(t))};
            FS_SLL:  y_lo = s << sh;
            FS_SRL:  y_lo = s >> sh;
            FS_SRA:  y_lo = $signed(s) >>> sh;
            FS_MULS: {y_hi, y_lo} = prod_s;
            FS_MULU: {y_hi, y_lo} = prod_u;
            default: begin
                y_lo = '0;
                y_hi = '0;
            end
        endcase
        n = is_mul ? y_hi[LANE_W-1] : y_lo[LANE_W-1];
        z = is_mul ? ({y_hi, y_lo} == '0) : (y_lo == '0);
    end

endmodule

// File: rtl/simd_vec_exec.sv
// Parametrised SIMD execute unit: masked lane ALUs into LO/HI banks with flags,
// random read-back and a valid/ready lane-by-lane drain port.
module simd_vec_exec
    import simd_pkg::*;
#(
    parameter  int unsigned LANES  = 8,
    parameter  int unsigned LANE_W = 32,
    localparam int unsigned IDX_W  = clog2(LANES)
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [3:0]                fs,
    input  logic [LANES-1:0]          lane_mask,
    input  logic                      lo_ld,
    input  logic                      hi_ld,
    input  logic [LANES*LANE_W-1:0]   s_vec,
    input  logic [LANES*LANE_W-1:0]   t_vec,
    input  logic [IDX_W:0]            rd_sel,
    output logic [LANE_W-1:0]         rd_data,
    input  logic                      drain_start,
    input  logic                      drain_hi,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [LANE_W-1:0]         out_data,
    output logic [IDX_W-1:0]          out_lane,
    output logic                      out_last,
    output logic                      busy,
    output logic [LANES-1:0]          flag_c,
    output logic [LANES-1:0]          flag_v,
    output logic [LANES-1:0]          flag_n,
    output logic [LANES-1:0]          flag_z
);

    state_t                    state;
    logic [3:0]                fs_q;
    logic [LANES-1:0]          mask_q;
    logic                      lo_ld_q;
    logic                      hi_ld_q;
    logic [LANES*LANE_W-1:0]   s_q;
    logic [LANES*LANE_W-1:0]   t_q;
    logic [IDX_W-1:0]          ptr;
    logic                      drain_hi_q;

    logic [LANE_W-1:0]         lo_bank [LANES];
    logic [LANE_W-1:0]         hi_bank [LANES];

    logic [LANE_W-1:0]         alu_lo [LANES];
    logic [LANE_W-1:0]         alu_hi [LANES];
    logic [LANES-1:0]          alu_c;
    logic [LANES-1:0]          alu_v;
    logic [LANES-1:0]          alu_n;
    logic [LANES-1:0]          alu_z;

    for (genvar g = 0; g < LANES; g++) begin : g_lane
        simd_lane_alu #(.LANE_W(LANE_W)) u_alu (
            .s    (s_q[g*LANE_W +: LANE_W]),
            .t    (t_q[g*LANE_W +: LANE_W]),
            .fs   (fs_q),
            .y_lo (alu_lo[g]),
            .y_hi (alu_hi[g]),
            .c    (alu_c[g]),
            .v    (alu_v[g]),
            .n    (alu_n[g]),
            .z    (alu_z[g])
        );
    end

    assign in_ready  = (state == ST_IDLE) && !drain_start && reset;
    assign busy      = (state != ST_IDLE);
    assign out_valid = (state == ST_DRAIN);
    assign out_lane  = ptr;
    assign out_last  = (ptr == IDX_W'(LANES-1));
    assign out_data  = drain_hi_q ? hi_bank[ptr] : lo_bank[ptr];
    assign rd_data   = rd_sel[IDX_W] ? hi_bank[rd_sel[IDX_W-1:0]] : lo_bank[rd_sel[IDX_W-1:0]];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= ST_IDLE;
            fs_q       <= '0;
            mask_q     <= '0;
            lo_ld_q    <= 1'b0;
            hi_ld_q    <= 1'b0;
            s_q        <= '0;
            t_q        <= '0;
            ptr        <= '0;
            drain_hi_q <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (drain_start) begin
                        drain_hi_q <= drain_hi;
                        ptr        <= '0;
                        state      <= ST_DRAIN;
                    end else if (in_valid && in_ready) begin
                        fs_q    <= fs;
                        mask_q  <= lane_mask;
                        lo_ld_q <= lo_ld;
                        hi_ld_q <= hi_ld;
                        s_q     <= s_vec;
                        t_q     <= t_vec;
                        state   <= ST_EXEC;
                    end
                end
                ST_EXEC: state <= ST_IDLE;
                ST_DRAIN: begin
                    if (out_ready) begin
                        // LANES is a power of two, so the pointer wraps back to 0 after the last lane.
                        ptr <= ptr + IDX_W'(1);
                        if (out_last) state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int unsigned i = 0; i < LANES; i++) begin
                lo_bank[i] <= '0;
                hi_bank[i] <= '0;
            end
            flag_c <= '0;
            flag_v <= '0;
            flag_n <= '0;
            flag_z <= '0;
        end else if (state == ST_EXEC) begin
            for (int unsigned i = 0; i < LANES; i++) begin
                if (mask_q[i]) begin
                    if (lo_ld_q) lo_bank[i] <= alu_lo[i];
                    if (hi_ld_q) hi_bank[i] <= alu_hi[i];
                    flag_c[i] <= alu_c[i];
                    flag_v[i] <= alu_v[i];
                    flag_n[i] <= alu_n[i];
                    flag_z[i] <= alu_z[i];
                end
            end
        end
    end

endmodule

// File: tb/tb_simd_vec_exec.sv
// Directed self-checking bench for simd_vec_exec (LANES=8, LANE_W=32).
module tb_simd_vec_exec;
    import simd_pkg::*;

    localparam int unsigned LANES  = 8;
    localparam int unsigned LANE_W = 32;
    localparam int unsigned IDX_W  = 3;

    logic                    clk = 1'b0;
    logic                    reset = 1'b0;
    logic                    in_valid = 1'b0;
    logic                    in_ready;
    logic [3:0]              fs = '0;
    logic [LANES-1:0]        lane_mask = '0;
    logic                    lo_ld = 1'b0;
    logic                    hi_ld = 1'b0;
    logic [LANES*LANE_W-1:0] s_vec = '0;
    logic [LANES*LANE_W-1:0] t_vec = '0;
    logic [IDX_W:0]          rd_sel = '0;
    logic [LANE_W-1:0]       rd_data;
    logic                    drain_start = 1'b0;
    logic                    drain_hi = 1'b0;
    logic                    out_valid;
    logic                    out_ready = 1'b0;
    logic [LANE_W-1:0]       out_data;
    logic [IDX_W-1:0]        out_lane;
    logic                    out_last;
    logic                    busy;
    logic [LANES-1:0]        flag_c, flag_v, flag_n, flag_z;

    int n_assert = 0;
    int n_fail   = 0;

    simd_vec_exec #(.LANES(LANES), .LANE_W(LANE_W)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .fs(fs), .lane_mask(lane_mask), .lo_ld(lo_ld), .hi_ld(hi_ld),
        .s_vec(s_vec), .t_vec(t_vec), .rd_sel(rd_sel), .rd_data(rd_data),
        .drain_start(drain_start), .drain_hi(drain_hi), .out_valid(out_valid),
        .out_ready(out_ready), .out_data(out_data), .out_lane(out_lane),
        .out_last(out_last), .busy(busy), .flag_c(flag_c), .flag_v(flag_v),
        .flag_n(flag_n), .flag_z(flag_z)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic rd_chk(input string tag, input logic bank, input int unsigned lane, input logic [31:0] exp);
        rd_sel = {bank, IDX_W'(lane)};
        #1;
        chk($sformatf("%s[%0d]", tag, lane), 64'(rd_data), 64'(exp));
    endtask

    task automatic set_uniform(input logic [31:0] sv, input logic [31:0] tv);
        for (int i = 0; i < LANES; i++) begin
            s_vec[i*LANE_W +: LANE_W] = sv;
            t_vec[i*LANE_W +: LANE_W] = tv;
        end
    endtask

    task automatic issue(input logic [3:0] f, input logic [7:0] m, input logic lo, input logic hi);
        fs = f; lane_mask = m; lo_ld = lo; hi_ld = hi;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
    endtask

    initial begin
        // Reset
        repeat (3) @(posedge clk);
        #1;
        chk("in_ready_in_reset", 64'(in_ready), 64'(0));
        chk("out_valid_in_reset", 64'(out_valid), 64'(0));
        reset = 1'b1;
        #1;
        for (int i = 0; i < 2*LANES; i++) begin
            rd_sel = IDX_W'(i) | ((i >= LANES) ? 4'b1000 : 4'b0000);
            #1;
            chk($sformatf("rst_rd[%0d]", i), 64'(rd_data), 64'(0));
        end
        chk("rst_flags", 64'({flag_c, flag_v, flag_n, flag_z}), 64'(0));
        chk("rst_in_ready", 64'(in_ready), 64'(1));
        chk("rst_busy", 64'(busy), 64'(0));
        chk("rst_out_lane", 64'(out_lane), 64'(0));

        // Masked add with signed overflow on lane 0; result lands one cycle after acceptance
        @(posedge clk); #1;
        for (int i = 0; i < LANES; i++) begin
            s_vec[i*LANE_W +: LANE_W] = 32'h7FFF_FFFF + 32'(i);
            t_vec[i*LANE_W +: LANE_W] = 32'd1;
        end
        fs = FS_ADD; lane_mask = 8'h0F; lo_ld = 1'b1; hi_ld = 1'b0;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        chk("exec_busy", 64'(busy), 64'(1));
        chk("exec_in_ready", 64'(in_ready), 64'(0));
        rd_sel = 4'd0; #1;
        chk("add_lo0_not_yet", 64'(rd_data), 64'(0));
        @(posedge clk); #1;
        chk("add_busy_done", 64'(busy), 64'(0));
        rd_chk("add_lo", 1'b0, 0, 32'h8000_0000);
        rd_chk("add_lo", 1'b0, 1, 32'h8000_0001);
        rd_chk("add_lo", 1'b0, 3, 32'h8000_0003);
        for (int i = 4; i < LANES; i++) rd_chk("add_lo_unmasked", 1'b0, i, 32'h0);
        chk("add_v", 64'(flag_v), 64'(8'h01));
        chk("add_n", 64'(flag_n), 64'(8'h0F));
        chk("add_c", 64'(flag_c), 64'(8'h00));
        chk("add_z", 64'(flag_z), 64'(8'h00));

        // Subtract with borrow, then equal operands
        set_uniform(32'd0, 32'd1);
        issue(FS_SUB, 8'hFF, 1'b1, 1'b0);
        rd_chk("sub_lo", 1'b0, 0, 32'hFFFF_FFFF);
        rd_chk("sub_lo", 1'b0, 7, 32'hFFFF_FFFF);
        chk("sub_c", 64'(flag_c), 64'(8'h00));
        chk("sub_n", 64'(flag_n), 64'(8'hFF));
        chk("sub_z", 64'(flag_z), 64'(8'h00));
        chk("sub_v", 64'(flag_v), 64'(8'h00));
        set_uniform(32'd5, 32'd5);
        issue(FS_SUB, 8'hFF, 1'b1, 1'b0);
        rd_chk("sub0_lo", 1'b0, 2, 32'h0);
        chk("sub0_c", 64'(flag_c), 64'(8'hFF));
        chk("sub0_z", 64'(flag_z), 64'(8'hFF));
        chk("sub0_n", 64'(flag_n), 64'(8'h00));

        // Signed and unsigned multiply of -1 * 2
        set_uniform(32'hFFFF_FFFF, 32'd2);
        issue(FS_MULS, 8'hFF, 1'b1, 1'b1);
        rd_chk("muls_lo", 1'b0, 4, 32'hFFFF_FFFE);
        rd_chk("muls_hi", 1'b1, 4, 32'hFFFF_FFFF);
        chk("muls_n", 64'(flag_n), 64'(8'hFF));
        chk("muls_z", 64'(flag_z), 64'(8'h00));
        issue(FS_MULU, 8'hFF, 1'b1, 1'b1);
        rd_chk("mulu_lo", 1'b0, 6, 32'hFFFF_FFFE);
        rd_chk("mulu_hi", 1'b1, 6, 32'h0000_0001);
        chk("mulu_n", 64'(flag_n), 64'(8'h00));

        // Empty mask: op runs but nothing changes
        set_uniform(32'd0, 32'd0);
        issue(FS_PASS, 8'h00, 1'b1, 1'b1);
        rd_chk("mask0_lo", 1'b0, 6, 32'hFFFF_FFFE);
        rd_chk("mask0_hi", 1'b1, 6, 32'h0000_0001);
        chk("mask0_z", 64'(flag_z), 64'(8'h00));

        // Shifts and SLT on LO only; HI keeps the unsigned-mul value
        for (int i = 0; i < LANES; i++) begin
            s_vec[i*LANE_W +: LANE_W] = 32'd1;
            t_vec[i*LANE_W +: LANE_W] = 32'(i) | 32'hFFFF_FF00;
        end
        issue(FS_SLL, 8'hFF, 1'b1, 1'b0);
        rd_chk("sll_lo", 1'b0, 5, 32'h0000_0020);
        rd_chk("sll_hi_kept", 1'b1, 5, 32'h0000_0001);
        set_uniform(32'h8000_0000, 32'd4);
        issue(FS_SRA, 8'hFF, 1'b1, 1'b0);
        rd_chk("sra_lo", 1'b0, 1, 32'hF800_0000);
        issue(FS_SRL, 8'hFF, 1'b1, 1'b0);
        rd_chk("srl_lo", 1'b0, 1, 32'h0800_0000);
        set_uniform(32'hFFFF_FFFF, 32'd0);
        issue(FS_SLT, 8'hFF, 1'b1, 1'b0);
        rd_chk("slt_lo", 1'b0, 3, 32'h1);

        // HI drain without backpressure
        drain_hi = 1'b1; drain_start = 1'b1; out_ready = 1'b1;
        tick();
        drain_start = 1'b0;
        for (int i = 0; i < LANES; i++) begin
            chk($sformatf("drhi_data[%0d]", i), 64'(out_data), 64'(1));
            chk($sformatf("drhi_lane[%0d]", i), 64'(out_lane), 64'(i));
            tick();
        end
        chk("drhi_done", 64'(out_valid), 64'(0));
        out_ready = 1'b0;

        // Load LO with 0x100+i
        for (int i = 0; i < LANES; i++) s_vec[i*LANE_W +: LANE_W] = 32'h100 + 32'(i);
        issue(FS_PASS, 8'hFF, 1'b1, 1'b0);

        // Drain LO with backpressure; concurrent in_valid must be refused
        set_uniform(32'd0, 32'd0);
        fs = FS_PASS; lane_mask = 8'hFF; lo_ld = 1'b1; hi_ld = 1'b0;
        drain_hi = 1'b0; drain_start = 1'b1; in_valid = 1'b1;
        #1;
        chk("drain_prio_in_ready", 64'(in_ready), 64'(0));
        tick();
        drain_start = 1'b0; in_valid = 1'b0;
        chk("drain_busy", 64'(busy), 64'(1));
        for (int i = 0; i < LANES; i++) begin
            chk($sformatf("dr_valid[%0d]", i), 64'(out_valid), 64'(1));
            chk($sformatf("dr_data[%0d]", i), 64'(out_data), 64'(32'h100 + i));
            chk($sformatf("dr_lane[%0d]", i), 64'(out_lane), 64'(i));
            chk($sformatf("dr_last[%0d]", i), 64'(out_last), 64'(i == LANES-1));
            tick();
            chk($sformatf("dr_hold_data[%0d]", i), 64'(out_data), 64'(32'h100 + i));
            chk($sformatf("dr_hold_lane[%0d]", i), 64'(out_lane), 64'(i));
            out_ready = 1'b1;
            tick();
            out_ready = 1'b0;
        end
        chk("dr_end_valid", 64'(out_valid), 64'(0));
        chk("dr_end_busy", 64'(busy), 64'(0));
        rd_chk("dr_op_refused", 1'b0, 0, 32'h100);

        // Reset in the middle of a drain
        drain_start = 1'b1;
        tick();
        drain_start = 1'b0;
        out_ready = 1'b1;
        repeat (3) tick();
        chk("mid_lane", 64'(out_lane), 64'(3));
        chk("mid_data", 64'(out_data), 64'(32'h103));
        reset = 1'b0;
        #1;
        chk("mid_rst_valid", 64'(out_valid), 64'(0));
        chk("mid_rst_busy", 64'(busy), 64'(0));
        chk("mid_rst_lane", 64'(out_lane), 64'(0));
        rd_chk("mid_rst_lo", 1'b0, 5, 32'h0);
        tick();
        reset = 1'b1;
        tick();
        drain_start = 1'b1;
        tick();
        drain_start = 1'b0;
        for (int i = 0; i < LANES; i++) begin
            chk($sformatf("rd2_valid[%0d]", i), 64'(out_valid), 64'(1));
            chk($sformatf("rd2_data[%0d]", i), 64'(out_data), 64'(0));
            chk($sformatf("rd2_lane[%0d]", i), 64'(out_lane), 64'(i));
            tick();
        end
        chk("rd2_end_valid", 64'(out_valid), 64'(0));
        out_ready = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
